// File: rtl/router.sv
// router: five-port XY-routed mesh NoC router with per-input FIFOs,
// per-output credit counters and round-robin arbitration (port order N,S,E,W,L)
module router #(
    parameter logic [3:0] X_ADDR = 4'd0,
    parameter logic [3:0] Y_ADDR = 4'd0,
    parameter int BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] north_i,
    input  logic [15:0] south_i,
    input  logic [15:0] east_i,
    input  logic [15:0] west_i,
    input  logic [15:0] local_i,
    input  logic        n_incr_i,
    input  logic        s_incr_i,
    input  logic        e_incr_i,
    input  logic        w_incr_i,
    input  logic        l_incr_i,
    output logic [15:0] north_o,
    output logic [15:0] south_o,
    output logic [15:0] east_o,
    output logic [15:0] west_o,
    output logic [15:0] local_o,
    output logic        n_incr_o,
    output logic        s_incr_o,
    output logic        e_incr_o,
    output logic        w_incr_o,
    output logic        l_incr_o
);
    localparam int AW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH = CW'(BUF_DEPTH);
    localparam logic [AW-1:0] LAST = AW'(BUF_DEPTH - 1);

    logic [15:0] flit_in [5];
    logic [15:0] flit_out [5];
    logic [15:0] head [5];
    logic [4:0]  req [5];
    logic [4:0]  gnt [5];
    logic [4:0]  incr_in;
    logic [4:0]  incr_out;

    assign flit_in[0] = north_i;
    assign flit_in[1] = south_i;
    assign flit_in[2] = east_i;
    assign flit_in[3] = west_i;
    assign flit_in[4] = local_i;
    assign incr_in = {l_incr_i, w_incr_i, e_incr_i, s_incr_i, n_incr_i};
    assign north_o = flit_out[0];
    assign south_o = flit_out[1];
    assign east_o = flit_out[2];
    assign west_o = flit_out[3];
    assign local_o = flit_out[4];
    assign {l_incr_o, w_incr_o, e_incr_o, s_incr_o, n_incr_o} = incr_out;

    for (genvar i = 0; i < 5; i++) begin : g_in
        logic [15:0]   mem [BUF_DEPTH];
        logic [AW-1:0] rd, wr;
        logic [CW-1:0] cnt;
        logic [3:0]    dx, dy;
        logic          wr_en, deq, pulse;
        assign head[i] = mem[rd];
        assign dx = head[i][14:11];
        assign dy = head[i][10:7];
        assign wr_en = flit_in[i][15] && cnt != DEPTH;
        assign deq = gnt[0][i] | gnt[1][i] | gnt[2][i] | gnt[3][i] | gnt[4][i];
        // one-hot output request of the head flit: X first, then Y
        assign req[i] = cnt == '0 ? 5'b00000 :
                        dx > X_ADDR ? 5'b00100 :
                        dx < X_ADDR ? 5'b01000 :
                        dy > Y_ADDR ? 5'b00001 :
                        dy < Y_ADDR ? 5'b00010 : 5'b10000;
        assign incr_out[i] = pulse;
        always_ff @(posedge clk)
            if (wr_en) mem[wr] <= flit_in[i];
        always_ff @(posedge clk) begin
            if (!rst) begin
                rd <= '0;
                wr <= '0;
                cnt <= '0;
                pulse <= 1'b0;
            end else begin
                if (wr_en) wr <= wr == LAST ? '0 : wr + 1'b1;
                if (deq) rd <= rd == LAST ? '0 : rd + 1'b1;
                cnt <= cnt + CW'(wr_en) - CW'(deq);
                pulse <= deq;
            end
        end
    end

    for (genvar o = 0; o < 5; o++) begin : g_out
        logic [4:0]    elig, rot;
        logic [2:0]    ptr, off, win;
        logic [3:0]    sum;
        logic [CW-1:0] cred;
        logic [15:0]   out;
        logic          any, ret;
        assign elig = cred == '0 ? 5'b00000 : {req[4][o], req[3][o], req[2][o], req[1][o], req[0][o]};
        // rotate so that bit 0 is the input the pointer currently favours
        assign rot = 5'({elig, elig} >> ptr);
        assign off = rot[0] ? 3'd0 : rot[1] ? 3'd1 : rot[2] ? 3'd2 : rot[3] ? 3'd3 : 3'd4;
        assign any = |elig;
        assign sum = {1'b0, ptr} + {1'b0, off};
        assign win = sum >= 4'd5 ? 3'(sum - 4'd5) : sum[2:0];
        assign gnt[o] = any ? 5'b00001 << win : 5'b00000;
        assign ret = incr_in[o];
        assign flit_out[o] = out;
        always_ff @(posedge clk) begin
            if (!rst) begin
                ptr <= 3'd0;
                cred <= DEPTH;
                out <= '0;
            end else begin
                out <= any ? head[win] : '0;
                if (any) ptr <= win == 3'd4 ? 3'd0 : win + 3'd1;
                if (any && !ret) cred <= cred - 1'b1;
                else if (!any && ret && cred != DEPTH) cred <= cred + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_router.sv
// tb_router: scoreboard bench for router with a queue-based reference model
module tb_router;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] fin [5];
    logic [15:0] fout [5];
    logic [4:0]  inc_i;
    logic [4:0]  inc_o;

    router #(.X_ADDR(4'd1), .Y_ADDR(4'd1), .BUF_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .north_i(fin[0]), .south_i(fin[1]), .east_i(fin[2]), .west_i(fin[3]), .local_i(fin[4]),
        .n_incr_i(inc_i[0]), .s_incr_i(inc_i[1]), .e_incr_i(inc_i[2]), .w_incr_i(inc_i[3]), .l_incr_i(inc_i[4]),
        .north_o(fout[0]), .south_o(fout[1]), .east_o(fout[2]), .west_o(fout[3]), .local_o(fout[4]),
        .n_incr_o(inc_o[0]), .s_incr_o(inc_o[1]), .e_incr_o(inc_o[2]), .w_incr_o(inc_o[3]), .l_incr_o(inc_o[4])
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int cyc = 0;

    // reference model state: input queues, credits, round-robin pointers
    logic [15:0] mq [5][$];
    int cred [5];
    int ptr [5];
    int msz [5];
    bit mdeq [5];
    bit msent [5];
    int mi;

    // scoreboard: expected flits/cycles per output, expected credit-return cycles per input
    logic [15:0] eq_f [5][$];
    int eq_c [5][$];
    int ei_c [5][$];

    int emit [5];
    int incc [5];
    logic [6:0] epl [$];
    int ecyc [$];
    logic [15:0] mf;
    int mc;

    int e0 [5];
    int ic4;
    int ord [4] = '{0, 1, 3, 4};
    logic [15:0] rf [5];
    logic [4:0] ri;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int route(input logic [15:0] f);
        if (f[14:11] > 4'd1) return 2;
        if (f[14:11] < 4'd1) return 3;
        if (f[10:7] > 4'd1) return 0;
        if (f[10:7] < 4'd1) return 1;
        return 4;
    endfunction

    function automatic logic [15:0] mk(input logic [3:0] x, input logic [3:0] y, input logic [6:0] p);
        return {1'b1, x, y, p};
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            for (int o = 0; o < 5; o++) begin
                mq[o].delete();
                cred[o] = D;
                ptr[o] = 0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                msz[i] = mq[i].size();
                mdeq[i] = 1'b0;
            end
            for (int o = 0; o < 5; o++) begin
                msent[o] = 1'b0;
                if (cred[o] > 0)
                    for (int k = 0; k < 5; k++) begin
                        mi = (ptr[o] + k) % 5;
                        if (!msent[o] && msz[mi] > 0 && route(mq[mi][0]) == o) begin
                            msent[o] = 1'b1;
                            mdeq[mi] = 1'b1;
                            eq_f[o].push_back(mq[mi][0]);
                            eq_c[o].push_back(cyc);
                            ei_c[mi].push_back(cyc);
                            ptr[o] = (mi + 1) % 5;
                        end
                    end
            end
            for (int i = 0; i < 5; i++)
                if (mdeq[i]) void'(mq[i].pop_front());
            for (int o = 0; o < 5; o++) begin
                cred[o] = cred[o] - int'(msent[o]) + int'(inc_i[o]);
                if (cred[o] > D) cred[o] = D;
            end
            for (int i = 0; i < 5; i++)
                if (fin[i][15] && msz[i] < D) mq[i].push_back(fin[i]);
        end
    end

    always @(negedge clk) begin
        for (int o = 0; o < 5; o++) begin
            if (fout[o][15]) begin
                emit[o]++;
                if (o == 2) begin
                    epl.push_back(fout[o][6:0]);
                    ecyc.push_back(cyc);
                end
                if (eq_f[o].size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected flit on output %0d: got %0h expected none (cycle %0d)", o, fout[o], cyc);
                end else begin
                    mf = eq_f[o].pop_front();
                    mc = eq_c[o].pop_front();
                    chk(fout[o] == mf, "flit value", 32'(fout[o]), 32'(mf));
                    chk(cyc == mc, "flit cycle", cyc, mc);
                end
            end else
                chk(fout[o] == 16'h0000, "idle output", 32'(fout[o]), 0);
            if (inc_o[o]) begin
                incc[o]++;
                if (ei_c[o].size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected incr_o on input %0d: got 1 expected 0 (cycle %0d)", o, cyc);
                end else begin
                    mc = ei_c[o].pop_front();
                    chk(cyc == mc, "incr_o cycle", cyc, mc);
                end
            end
        end
    end

    task automatic drive(input logic [15:0] n, input logic [15:0] s, input logic [15:0] e,
                         input logic [15:0] w, input logic [15:0] l, input logic [4:0] inc);
        fin[0] = n;
        fin[1] = s;
        fin[2] = e;
        fin[3] = w;
        fin[4] = l;
        inc_i = inc;
        @(negedge clk);
        for (int i = 0; i < 5; i++) fin[i] = '0;
        inc_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic snap();
        for (int o = 0; o < 5; o++) e0[o] = emit[o];
        ic4 = incc[4];
    endtask

    initial begin
        for (int i = 0; i < 5; i++) fin[i] = '0;
        inc_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk(emit[0] + emit[1] + emit[2] + emit[3] + emit[4] == 0, "idle after reset", 0, 0);

        snap();
        drive(0, 0, 0, 0, mk(4'd2, 4'd1, 7'h11), 0);
        drive(0, 0, 0, 0, mk(4'd0, 4'd1, 7'h22), 0);
        drive(0, 0, 0, 0, mk(4'd1, 4'd2, 7'h33), 0);
        drive(0, 0, 0, 0, mk(4'd1, 4'd0, 7'h44), 0);
        drive(0, 0, 0, 0, mk(4'd1, 4'd1, 7'h55), 0);
        repeat (6) @(negedge clk);
        for (int o = 0; o < 5; o++) chk(emit[o] - e0[o] == 1, "routing count", emit[o] - e0[o], 1);
        chk(incc[4] - ic4 == 5, "l_incr_o pulses", incc[4] - ic4, 5);

        do_reset();
        epl.delete();
        ecyc.delete();
        drive(mk(4'd2, 4'd0, 7'd0), mk(4'd2, 4'd2, 7'd1), 0, mk(4'd2, 4'd1, 7'd3), mk(4'd2, 4'd1, 7'd4), 0);
        repeat (8) @(negedge clk);
        chk(epl.size() == 4, "contention count", epl.size(), 4);
        if (epl.size() == 4) begin
            for (int k = 0; k < 4; k++) chk(epl[k] == 7'(ord[k]), "contention order", 32'(epl[k]), ord[k]);
            chk(ecyc[3] - ecyc[0] == 3, "contention back-to-back", ecyc[3] - ecyc[0], 3);
        end

        do_reset();
        snap();
        for (int k = 0; k < 6; k++) drive(0, 0, 0, 0, mk(4'd3, 4'd1, 7'(k)), 0);
        repeat (8) @(negedge clk);
        chk(emit[2] - e0[2] == 4, "credit exhaustion", emit[2] - e0[2], 4);
        drive(0, 0, 0, 0, 0, 5'b00100);
        drive(0, 0, 0, 0, 0, 5'b00100);
        repeat (6) @(negedge clk);
        chk(emit[2] - e0[2] == 6, "credit return", emit[2] - e0[2], 6);

        do_reset();
        ecyc.delete();
        for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, mk(4'd2, 4'd1, 7'(k)), 0);
        drive(0, 0, 0, 0, mk(4'd2, 4'd1, 7'd4), 5'b00100);
        repeat (6) @(negedge clk);
        chk(ecyc.size() == 5, "send+return count", ecyc.size(), 5);
        if (ecyc.size() == 5) chk(ecyc[4] - ecyc[0] == 4, "send+return back-to-back", ecyc[4] - ecyc[0], 4);
        drive(0, 0, 0, 0, mk(4'd2, 4'd1, 7'd5), 0);
        repeat (4) @(negedge clk);
        chk(ecyc.size() == 5, "credit left at zero", ecyc.size(), 5);

        do_reset();
        for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, mk(4'd2, 4'd1, 7'(k)), 0);
        drive(mk(4'd2, 4'd0, 7'd10), mk(4'd2, 4'd2, 7'd11), 0, mk(4'd2, 4'd1, 7'd13), 0, 0);
        do_reset();
        snap();
        repeat (6) @(negedge clk);
        chk(emit[2] - e0[2] == 0, "flits after reset", emit[2] - e0[2], 0);
        for (int k = 0; k < 20; k++)
            case (k % 5)
                0: drive(0, 0, 0, 0, mk(4'd1, 4'd2, 7'(k)), 0);
                1: drive(0, 0, 0, 0, mk(4'd1, 4'd0, 7'(k)), 0);
                2: drive(0, 0, 0, 0, mk(4'd2, 4'd1, 7'(k)), 0);
                3: drive(0, 0, 0, 0, mk(4'd0, 4'd1, 7'(k)), 0);
                default: drive(0, 0, 0, 0, mk(4'd1, 4'd1, 7'(k)), 0);
            endcase
        repeat (8) @(negedge clk);
        for (int o = 0; o < 5; o++) chk(emit[o] - e0[o] == 4, "credits restored", emit[o] - e0[o], 4);

        do_reset();
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 5; i++)
                rf[i] = $urandom_range(0, 9) < 3 ?
                        mk(4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)), 7'($urandom)) : 16'h0000;
            ri = 5'($urandom);
            drive(rf[0], rf[1], rf[2], rf[3], rf[4], ri);
        end
        repeat (30) drive(0, 0, 0, 0, 0, 5'b11111);
        for (int o = 0; o < 5; o++) begin
            chk(eq_f[o].size() == 0, "missing flits", eq_f[o].size(), 0);
            chk(ei_c[o].size() == 0, "missing incr_o", ei_c[o].size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/router.md
# router

Five-port, single-flit-packet mesh NoC router using credit-based flow control. It has North, South, East, West and Local ports, each carrying 16-bit flits. Every input port buffers flits in a FIFO. Each flit is routed dimension-ordered (X first, then Y) to one output port. Each output port arbitrates round-robin among the inputs that request it. The router is instantiated once per mesh node, and its Local port connects to the node's network interface.

## Interface
- `X_ADDR`, default 0: this node's X coordinate (4 bits).
- `Y_ADDR`, default 0: this node's Y coordinate (4 bits).
- `BUF_DEPTH`, default 4: input FIFO depth. This is also the initial credit count per output.
- `clk` input, 1 bit: single clock; all logic is on the rising edge.
- `rst` input, 1 bit: reset is synchronous and active-low.
- `north_i`, `south_i`, `east_i`, `west_i`, `local_i` input, 16 bits each: incoming flits.
- `n_incr_i`, `s_incr_i`, `e_incr_i`, `w_incr_i`, `l_incr_i` input, 1 bit each: credit-return pulses from the downstream receiver on that output.
- `north_o`, `south_o`, `east_o`, `west_o`, `local_o` output, 16 bits each: outgoing flits.
- `n_incr_o`, `s_incr_o`, `e_incr_o`, `w_incr_o`, `l_incr_o` output, 1 bit each: credit-return pulses to the upstream sender on that input.

## Operation
- Flit format:
  - [15] is the valid bit.
  - [14:11] is the destination X.
  - [10:7] is the destination Y.
  - [6:0] is the payload, passed through unmodified.
- A flit whose valid bit is 0 is idle and is ignored.
- Each input has a FIFO of depth BUF_DEPTH. A valid flit is written on the clock edge where it is present.
- A write into a full FIFO drops the flit. This is a protocol violation, and the FIFO contents stay intact.
- Routing of the head flit of each FIFO:
  - dest X > X_ADDR: East.
  - dest X < X_ADDR: West.
  - dest X = X_ADDR and dest Y > Y_ADDR: North.
  - dest X = X_ADDR and dest Y < Y_ADDR: South.
  - Both coordinates equal: Local. This applies to any input, including Local.
- Each output keeps a credit counter, range 0..BUF_DEPTH, with reset value BUF_DEPTH.
  - Sending a flit decrements the counter.
  - An `*_incr_i` pulse increments the counter.
  - A send and a pulse in the same cycle leave the counter unchanged.
  - The counter saturates at BUF_DEPTH; excess pulses are ignored.
- An output is eligible only when its credit counter is greater than 0.
- Arbitration per output:
  - Round-robin in the fixed order N, S, E, W, L.
  - The pointer starts at N after reset.
  - After a grant, the pointer moves to the input following the winner.
  - The pointer does not move when there is no grant.
- Each input dequeues at most one flit per cycle, and each output sends at most one flit per cycle.
- A blocked head flit blocks its FIFO. Head-of-line blocking is accepted.
- When an input's head flit is granted, it is dequeued. The matching `*_incr_o` pulses high for exactly one cycle.

## Timing
- Reset values, applied at the first rising edge with `rst` = 0:
  - All `*_o` flit outputs are 16'h0000.
  - All `*_incr_o` outputs are 0.
  - FIFOs are empty.
  - Credit counters are BUF_DEPTH.
  - RR pointers are at N.
- If reset is asserted mid-operation, buffered flits are discarded and no credit pulses are emitted.
- Cycle-level path for a flit:
  - It is sampled into the FIFO at edge k.
  - It is arbitrated in cycle k..k+1.
  - It is registered to the output at edge k+1.
  - Minimum latency is therefore 2 edges from input sample to output visible.
- The `*_incr_o` pulse is registered and asserts in the same cycle the dequeued flit appears on its output.
- Output flits are registered. A flit is held for exactly one cycle; in cycles with no send the output is 16'h0000.
- A flit written into an empty FIFO can be granted at the next edge; there is no bypass.
- An `*_incr_i` pulse at edge k makes the credit usable for arbitration in the cycle after edge k.

## Test plan
- Reset and idle:
  - Hold `rst`=0 for 2 cycles, then release, with all inputs 0.
  - Required: all outputs stay 16'h0000 and all incr outputs stay 0.
- XY routing, with X_ADDR=1 and Y_ADDR=1:
  - Inject on `local_i` flits with (x,y) = (2,1), (0,1), (1,2), (1,0), (1,1).
  - Required: each appears on `east_o`, `west_o`, `north_o`, `south_o` and `local_o` respectively, 2 edges after injection, with payload intact.
  - Required: `l_incr_o` pulses once per flit.
- Contention:
  - N, S, W and L inputs each send one flit to East in the same cycle.
  - Required: `east_o` emits them on 4 consecutive cycles in the order N, S, W, L.
- Credit exhaustion:
  - With BUF_DEPTH=4 and no `e_incr_i` pulses, send 6 flits to East.
  - Required: exactly 4 emerge.
  - Then pulse `e_incr_i` twice; required: the remaining 2 emerge.
- Simultaneous send and credit return:
  - With credit at 1, pulse `e_incr_i` in the same cycle a flit is sent.
  - Required: the credit stays at 1 and the next queued flit is sent the following cycle.
- Mid-stream reset:
  - Assert `rst` while 3 flits are buffered.
  - Required: no flits emerge after reset, and all 5 credit counters are back at 4, checked by being able to send 4 flits per output again.
